main_control_fsm: RTL and testbench
===================================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter: STATE_W, 4, width of the encoded state output.
REQ-002 Port: clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: Op  input  6  opcode field Instr[31:26] from the instruction register.
REQ-005 Port: Mem_Ready  input  1  memory completion handshake, sampled in FETCH, MEMRD and MEMWR.
REQ-006 Ports, each output 1 bit: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA; these are datapath strobes and selects.
REQ-007 Ports, each output 2 bits: ALUSrcB, ALUOp, PCSource, Zero_Sign; Zero_Sign drives the extender mode.
REQ-008 Port: Illegal_Op  output  1  one-cycle pulse on an unsupported opcode.
REQ-009 Port: State  output  STATE_W  current state encoding, for debug.

Function
REQ-010 The block SHALL be a Moore FSM; all outputs SHALL be combinational decodes of the current state only, and any output not listed for a state SHALL be 0.
REQ-011 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11; encodings 12-15 SHALL transition to FETCH.
REQ-012 Zero_Sign encoding SHALL be: 00 sign-extend, 01 zero-extend, 10 imm<<16 (lui), 11 sign-extend<<2 (branch offset).
REQ-013 FETCH outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite SHALL be 1 only when Mem_Ready=1. The FSM SHALL stay in FETCH while Mem_Ready=0 and go to DECODE when it is 1.
REQ-014 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00, Zero_Sign=11 (branch target precompute).
REQ-015 DECODE transitions by Op: 100011 (lw) or 101011 (sw) go to MEMADR; 000000 goes to RTEXEC; 000100 (beq) goes to BRANCH; 001000 (addi), 001100 (andi), 001101 (ori) and 001111 (lui) go to IMMEXEC; 000010 (j) goes to JUMP; any other opcode goes to FETCH with Illegal_Op=1 during that DECODE cycle.
REQ-016 MEMADR outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Zero_Sign=00. Next state is MEMRD for lw and MEMWR for sw.
REQ-017 MEMRD outputs: MemRead=1, IorD=1. The FSM SHALL hold while Mem_Ready=0 and go to MEMWB when Mem_Ready=1.
REQ-018 MEMWB outputs: RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
REQ-019 MEMWR outputs: MemWrite=1, IorD=1. The FSM SHALL hold while Mem_Ready=0 and go to FETCH when Mem_Ready=1.
REQ-020 RTEXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RTWB. RTWB outputs: RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-021 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Zero_Sign=11. Next state is FETCH.
REQ-022 IMMEXEC outputs: ALUSrcA=1, ALUSrcB=10. ALUOp SHALL be 00 for addi and lui and 11 for andi/ori. Zero_Sign SHALL be 00 for addi, 01 for andi/ori, and 10 for lui. Next state is IMMWB.
REQ-023 IMMWB outputs: RegWrite=1, RegDst=0, MemtoReg=0; Zero_Sign SHALL hold the IMMEXEC value. Next state is FETCH.
REQ-024 JUMP outputs: PCWrite=1, PCSource=10. Next state is FETCH.
REQ-025 Op SHALL be treated as stable from DECODE until the return to FETCH, because IRWrite is 0 in those states.
REQ-026 Instruction cycle counts with Mem_Ready tied to 1 SHALL be: lw 5, sw 4, R-type 4, addi/andi/ori/lui 4, beq 3, j 3.

Reset
REQ-027 When reset is asserted, State SHALL go to FETCH immediately, without waiting for clk, and all outputs SHALL take their FETCH decode.
REQ-028 Reset asserted in any state, including while waiting on Mem_Ready, SHALL abort the instruction with no further RegWrite, MemWrite or PCWrite pulse from that instruction.
REQ-029 After reset deasserts, the first rising clk edge SHALL evaluate the FETCH transition normally.

Verification
REQ-030 lw (Op=100011), Mem_Ready=1: State sequence 0,1,2,3,4,0; Zero_Sign=00 in MEMADR; MemtoReg=1 and RegWrite=1 only in MEMWB.
REQ-031 sw with Mem_Ready=0 for 3 cycles in MEMWR: State stays 5 for 4 cycles with MemWrite=1 throughout, then returns to 0; RegWrite=0 throughout.
REQ-032 andi, ori, lui, addi each: in IMMEXEC Zero_Sign is 01, 01, 10, 00 respectively; RegWrite=1 only in IMMWB.
REQ-033 beq: sequence 0,1,8,0 with PCWriteCond=1, PCSource=01, Zero_Sign=11 in BRANCH. j: sequence 0,1,11,0 with PCWrite=1, PCSource=10 in JUMP.
REQ-034 Op=111111: DECODE goes to FETCH with Illegal_Op=1 for exactly one cycle and no write strobes asserted.
REQ-035 Reset asserted mid-cycle while in MEMRD: State reads 0 before the next clk edge and RegWrite is never asserted for that lw.

Source files
------------

// File: rtl/main_control_fsm_if.sv
// Control bundle between the multicycle datapath and its main control FSM.
// The FSM sits on the slave side: it takes the opcode and memory handshake and drives every strobe.
interface main_control_fsm_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Op;
    logic               Mem_Ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               MemtoReg;
    logic               RegDst;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic [1:0]         Zero_Sign;
    logic               Illegal_Op;
    logic [STATE_W-1:0] State;

    modport master (
        output Op, Mem_Ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Zero_Sign,
               Illegal_Op, State
    );

    modport slave (
        input  Op, Mem_Ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Zero_Sign,
               Illegal_Op, State
    );
endinterface

// File: rtl/main_control_fsm.sv
// Main control FSM of the multicycle MIPS datapath.
// Outputs are decoded from the current state, so an async reset lands them on the FETCH decode at once.
module main_control_fsm #(
    parameter int STATE_W = 4
) (
    input logic               clk,
    input logic               reset,
    main_control_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTEXEC  = 4'd6,
        RTWB    = 4'd7,
        BRANCH  = 4'd8,
        IMMEXEC = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state;
    logic   logical_imm;
    logic   supported_op;
    logic [1:0] imm_ext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (bus.Mem_Ready) state <= DECODE;
                DECODE: begin
                    case (bus.Op)
                        OP_LW, OP_SW:                      state <= MEMADR;
                        OP_RTYPE:                          state <= RTEXEC;
                        OP_BEQ:                            state <= BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state <= IMMEXEC;
                        OP_J:                              state <= JUMP;
                        default:                           state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (bus.Op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (bus.Mem_Ready) state <= MEMWB;
                MEMWB:   state <= FETCH;
                MEMWR:   if (bus.Mem_Ready) state <= FETCH;
                RTEXEC:  state <= RTWB;
                RTWB:    state <= FETCH;
                BRANCH:  state <= FETCH;
                IMMEXEC: state <= IMMWB;
                IMMWB:   state <= FETCH;
                JUMP:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Op stays frozen past FETCH, so IMMEXEC/IMMWB can decode the extender mode straight from it.
    always_comb begin
        logical_imm  = (bus.Op == OP_ANDI) || (bus.Op == OP_ORI);
        imm_ext      = (bus.Op == OP_LUI) ? 2'b10 : (logical_imm ? 2'b01 : 2'b00);
        supported_op = (bus.Op == OP_LW)   || (bus.Op == OP_SW)   || (bus.Op == OP_RTYPE) ||
                       (bus.Op == OP_BEQ)  || (bus.Op == OP_ADDI) || (bus.Op == OP_ANDI)  ||
                       (bus.Op == OP_ORI)  || (bus.Op == OP_LUI)  || (bus.Op == OP_J);
    end

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.Zero_Sign   = 2'b00;
        bus.Illegal_Op  = 1'b0;
        case (state)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.Mem_Ready;
                bus.PCWrite = bus.Mem_Ready;
            end
            DECODE: begin
                bus.ALUSrcB    = 2'b11;
                bus.Zero_Sign  = 2'b11;
                bus.Illegal_Op = !supported_op;
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            RTEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end
            RTWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.Zero_Sign   = 2'b11;
            end
            IMMEXEC: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ALUOp     = logical_imm ? 2'b11 : 2'b00;
                bus.Zero_Sign = imm_ext;
            end
            IMMWB: begin
                bus.RegWrite  = 1'b1;
                bus.Zero_Sign = imm_ext;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.State = STATE_W'(state);

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed scenarios, then random instruction streams
// compared against per-instruction state paths and per-state output tables.
module tb_main_control_fsm;

    localparam int STATE_W = 4;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic [1:0] Zero_Sign;
        logic       Illegal_Op;
    } ctl_t;

    localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_BEQ = 3, C_IMM = 4, C_J = 5, C_ILL = 6;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    main_control_fsm_if #(.STATE_W(STATE_W)) bus ();

    main_control_fsm #(.STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_RT;
            6'b000100: return C_BEQ;
            6'b001000, 6'b001100, 6'b001101, 6'b001111: return C_IMM;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    // Expected strobes for one cycle, written as the per-state output table of the controller.
    function automatic ctl_t exp_out(input int st, input logic [5:0] op, input logic ready);
        ctl_t c;
        logic [1:0] ext;
        c   = '0;
        ext = (op == 6'b001111) ? 2'b10 :
              ((op == 6'b001100 || op == 6'b001101) ? 2'b01 : 2'b00);
        case (st)
            0:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = ready; c.PCWrite = ready; end
            1:  begin c.ALUSrcB = 2'b11; c.Zero_Sign = 2'b11; c.Illegal_Op = (op_class(op) == C_ILL); end
            2:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            3:  begin c.MemRead = 1; c.IorD = 1; end
            4:  begin c.RegWrite = 1; c.MemtoReg = 1; end
            5:  begin c.MemWrite = 1; c.IorD = 1; end
            6:  begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
            7:  begin c.RegWrite = 1; c.RegDst = 1; end
            8:  begin c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCWriteCond = 1; c.PCSource = 2'b01; c.Zero_Sign = 2'b11; end
            9:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUOp = (ext == 2'b01) ? 2'b11 : 2'b00; c.Zero_Sign = ext; end
            10: begin c.RegWrite = 1; c.Zero_Sign = ext; end
            11: begin c.PCWrite = 1; c.PCSource = 2'b10; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t observed();
        ctl_t c;
        c.PCWrite     = bus.PCWrite;
        c.PCWriteCond = bus.PCWriteCond;
        c.IorD        = bus.IorD;
        c.MemRead     = bus.MemRead;
        c.MemWrite    = bus.MemWrite;
        c.IRWrite     = bus.IRWrite;
        c.MemtoReg    = bus.MemtoReg;
        c.RegDst      = bus.RegDst;
        c.RegWrite    = bus.RegWrite;
        c.ALUSrcA     = bus.ALUSrcA;
        c.ALUSrcB     = bus.ALUSrcB;
        c.ALUOp       = bus.ALUOp;
        c.PCSource    = bus.PCSource;
        c.Zero_Sign   = bus.Zero_Sign;
        c.Illegal_Op  = bus.Illegal_Op;
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive Mem_Ready, check state and strobes mid-cycle, then advance.
    task automatic applyStimulus(input int exp_state, input logic ready, input logic [5:0] op, input string tag);
        bus.Mem_Ready = ready;
        #1;
        checkOutput($sformatf("%s_state%0d", tag, exp_state), 32'(bus.State), 32'(exp_state));
        checkOutput($sformatf("%s_outs%0d", tag, exp_state), 32'(observed()), 32'(exp_out(exp_state, op, ready)));
        @(posedge clk);
        #1;
    endtask

    // Expected state path of one whole instruction, derived from its class and the memory waits.
    task automatic run_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait, input string tag);
        int cls;
        cls    = op_class(op);
        bus.Op = op;
        for (int i = 0; i < fetch_wait; i++) applyStimulus(0, 1'b0, op, tag);
        applyStimulus(0, 1'b1, op, tag);
        applyStimulus(1, 1'($urandom), op, tag);
        case (cls)
            C_LW: begin
                applyStimulus(2, 1'($urandom), op, tag);
                for (int i = 0; i < mem_wait; i++) applyStimulus(3, 1'b0, op, tag);
                applyStimulus(3, 1'b1, op, tag);
                applyStimulus(4, 1'($urandom), op, tag);
            end
            C_SW: begin
                applyStimulus(2, 1'($urandom), op, tag);
                for (int i = 0; i < mem_wait; i++) applyStimulus(5, 1'b0, op, tag);
                applyStimulus(5, 1'b1, op, tag);
            end
            C_RT: begin
                applyStimulus(6, 1'($urandom), op, tag);
                applyStimulus(7, 1'($urandom), op, tag);
            end
            C_BEQ: applyStimulus(8, 1'($urandom), op, tag);
            C_IMM: begin
                applyStimulus(9, 1'($urandom), op, tag);
                applyStimulus(10, 1'($urandom), op, tag);
            end
            C_J:   applyStimulus(11, 1'($urandom), op, tag);
            default: ;
        endcase
    endtask

    task automatic measure_cycles(input logic [5:0] op, input int expected, input string tag);
        int n;
        n             = 0;
        bus.Op        = op;
        bus.Mem_Ready = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.State != 0 && n < 20);
        checkOutput(tag, 32'(n), 32'(expected));
    endtask

    logic [5:0] op_table [11];

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.Op        = 6'b0;
        bus.Mem_Ready = 1'b0;
        op_table = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b001100,
                     6'b001101, 6'b001111, 6'b000010, 6'b111111, 6'b010101};

        #1;
        checkOutput("reset_state", 32'(bus.State), 32'd0);
        checkOutput("reset_outs", 32'(observed()), 32'(exp_out(0, 6'b0, 1'b0)));
        @(posedge clk);
        #1;
        checkOutput("reset_hold_state", 32'(bus.State), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed instruction sequences");
        run_instr(6'b100011, 0, 0, "lw");
        run_instr(6'b101011, 1, 3, "sw_wait");
        run_instr(6'b001100, 0, 0, "andi");
        run_instr(6'b001101, 0, 0, "ori");
        run_instr(6'b001111, 0, 0, "lui");
        run_instr(6'b001000, 0, 0, "addi");
        run_instr(6'b000000, 0, 0, "rtype");
        run_instr(6'b000100, 0, 0, "beq");
        run_instr(6'b000010, 0, 0, "j");
        run_instr(6'b111111, 0, 0, "illegal");

        $display("[TB] reset during MEMRD wait");
        bus.Op = 6'b100011;
        applyStimulus(0, 1'b1, 6'b100011, "abort");
        applyStimulus(1, 1'b1, 6'b100011, "abort");
        applyStimulus(2, 1'b1, 6'b100011, "abort");
        applyStimulus(3, 1'b0, 6'b100011, "abort");
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_async_state", 32'(bus.State), 32'd0);
        checkOutput("abort_async_regwrite", 32'(bus.RegWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 6'b100011, "post_abort");
        applyStimulus(0, 1'b0, 6'b100011, "post_abort");

        $display("[TB] cycle counts with Mem_Ready tied high");
        measure_cycles(6'b100011, 5, "cyc_lw");
        measure_cycles(6'b101011, 4, "cyc_sw");
        measure_cycles(6'b000000, 4, "cyc_rtype");
        measure_cycles(6'b001101, 4, "cyc_ori");
        measure_cycles(6'b000100, 3, "cyc_beq");
        measure_cycles(6'b000010, 3, "cyc_j");

        $display("[TB] random instruction stream");
        for (int k = 0; k < 80; k++) begin
            int         idx;
            logic [5:0] op;
            idx = int'($urandom_range(0, 11));
            op  = (idx == 11) ? 6'($urandom) : op_table[idx];
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
